z_fsm_path_driver: RTL
======================

# z_fsm_path_driver

Stimulus-side companion to the two-input z-machine (4-state Moore FSM, inputs x/y, output z). Accepts a target-state request, drives the shortest x/y symbol sequence that steers the z-machine to that state, and tracks a cycle-accurate shadow of its state. The z-machine's z output is checked against the shadow every cycle. Sits directly in front of the z-machine: drv_x/drv_y feed its in_x/in_y, its out_z returns on obs_z, and both blocks share clk and reset_b.

## Interface
- CHECK_Z, default 1: enables z-mismatch detection; 0 ties err low.
- DWELL, default 0: extra cycles held at the target before done; counter width 4 bits, DWELL ≤ 15.
- clk  in  1  clock, rising edge.
- reset_b  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_target  in  2  requested z-machine state, 0..3.
- req_ready  out  1  driver can accept a request (IDLE and !err).
- obs_z  in  1  z output of the driven z-machine.
- drv_x, drv_y  out  1 each  registered symbol to the z-machine; symbol = {x,y}.
- busy  out  1  high in DRIVE.
- done  out  1  one-cycle pulse when the target has been reached and DWELL has elapsed.
- cur_state  out  2  shadow state.
- err  out  1  sticky z-mismatch flag.
- err_clr  in  1  synchronous clear for err.

## Operation
- z-machine model (next state for symbols 00/01/10/11; z=1 in S0 and S3 only):
  - S0 → S0/S2/S0/S1
  - S1 → S0/S2/S1/S2
  - S2 → S1/S2/S1/S3
  - S3 → S0/S3/S2/S0
- Shadow update every edge: shadow <= delta(shadow, {drv_x,drv_y}).
- Registered symbol update every edge: sym <= hop(shadow_next, tgt). In IDLE, tgt = shadow_next.
- hop(c,t): first symbol of a shortest path; ties go to the lowest symbol code.
  - Hold symbols (c == t): S0 00, S1 10, S2 01, S3 01.
  - From S0: →S1 11, →S2 01, →S3 01.
  - From S1: →S0 00, →S2 01, →S3 01.
  - From S2: →S0 00, →S1 00, →S3 11.
  - From S3: →S0 00, →S1 00, →S2 10.
  - Maximum path length is 2 hops.
- FSM states: IDLE, DRIVE.
  - IDLE: when req_valid && req_ready, latch tgt, clear the dwell count, go to DRIVE.
  - DRIVE: at each edge, if the pre-edge shadow == tgt:
    - dwell == DWELL: set done, go to IDLE.
    - otherwise: increment dwell.
  - DRIVE: if shadow != tgt, dwell stays 0.
- Z check, when CHECK_Z = 1: at every edge, if obs_z != z(shadow), set err.
  - err in DRIVE aborts to IDLE with no done.
  - Set has priority over err_clr in the same cycle.
  - req_ready stays low while err is high.

## Timing
- Reset values:
  - Shadow S0, sym 00, so drv_x = drv_y = 0.
  - FSM IDLE, tgt 0, dwell 0.
  - done 0, busy 0, err 0, req_ready 1.
  - cur_state 0.
- Acceptance at edge E0 with hop distance d (from the shadow at E0): done is high in the cycle after edge E(d+1+DWELL).
  - d=0, DWELL=0: done in the cycle after E1.
- drv_x/drv_y change only on clk edges and are glitch-free.
- The z-machine consumes each symbol at the same edge the shadow does.
- Back-to-back: req_ready is high in the done cycle, so a new request can be accepted at that cycle's edge.
- req_target changes while busy are ignored; only the latched tgt is used.
- Asynchronous reset mid-DRIVE: the request is dropped, no done pulse, all registers return to reset values.

## Structure
- Shared package z_fsm_pkg holds:
  - state encodings S0..S3 = 2'b00..2'b11;
  - symbol constants SYM00..SYM11;
  - the hold-symbol constants.
- Sub-module z_fsm_model: purely combinational delta(state, sym) and z(state).
  - Reused by the driver's shadow and by the verification scoreboard.
- hop() is a local function in the driver.

## Test plan
- Reset, then idle 3 cycles:
  - drv_x/drv_y = 0/0, cur_state = 0, obs_z = 1, err = 0.
- Request target 3 from S0, DWELL = 0:
  - Symbols 01, then 11.
  - cur_state 0 → 2 → 3.
  - done pulses in the cycle after E3.
  - Hold symbol 01 thereafter.
- Request target 1 from S3:
  - Symbols 00, then 11.
  - cur_state 3 → 0 → 1.
  - obs_z sequence 1, 1, 0.
  - No err.
- Request target equal to the current state (S2), with DWELL = 2:
  - done is high in the cycle after E3.
  - drv_x/drv_y stay 0/1.
- Force obs_z = 0 while the shadow is S0, during DRIVE:
  - err = 1 next cycle, busy drops, no done, req_ready = 0.
  - err_clr then restores req_ready = 1.
- Deassert reset_b mid-way through a 2-hop request:
  - Outputs return to reset values immediately.
  - No done pulse after release.
  - A fresh request to target 2 completes with symbol 01.

Source files
------------

// File: rtl/z_fsm_pkg.sv
// Shared encodings for the two-input z-machine and its path driver.
// The bench reuses these encodings alongside the driver.
package z_fsm_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } zstate_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } drv_state_e;

  localparam logic [1:0] SYM00 = 2'b00;
  localparam logic [1:0] SYM01 = 2'b01;
  localparam logic [1:0] SYM10 = 2'b10;
  localparam logic [1:0] SYM11 = 2'b11;

  // Symbols that keep the z-machine in its current state.
  localparam logic [1:0] HOLD_S0 = SYM00;
  localparam logic [1:0] HOLD_S1 = SYM10;
  localparam logic [1:0] HOLD_S2 = SYM01;
  localparam logic [1:0] HOLD_S3 = SYM01;

endpackage

// File: rtl/z_fsm_path_driver_if.sv
// Request, symbol and status signals between the requester and the path driver.
interface z_fsm_path_driver_if;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic       obs_z;
  logic       drv_x;
  logic       drv_y;
  logic       busy;
  logic       done;
  logic [1:0] cur_state;
  logic       err;
  logic       err_clr;

  modport master (
    output req_valid, req_target, obs_z, err_clr,
    input  req_ready, drv_x, drv_y, busy, done, cur_state, err
  );

  modport slave (
    input  req_valid, req_target, obs_z, err_clr,
    output req_ready, drv_x, drv_y, busy, done, cur_state, err
  );
endinterface

// File: rtl/z_fsm_model.sv
// Combinational z-machine: next state for a {x,y} symbol, and the Moore z output.
module z_fsm_model
  import z_fsm_pkg::*;
(
  input  logic [1:0] state,
  input  logic [1:0] sym,
  output logic [1:0] next,
  output logic       z
);

  always_comb begin
    next = state;
    unique case (zstate_e'(state))
      S0: begin
        unique case (sym)
          SYM00:   next = S0;
          SYM01:   next = S2;
          SYM10:   next = S0;
          default: next = S1;
        endcase
      end
      S1: begin
        unique case (sym)
          SYM00:   next = S0;
          SYM01:   next = S2;
          SYM10:   next = S1;
          default: next = S2;
        endcase
      end
      S2: begin
        unique case (sym)
          SYM00:   next = S1;
          SYM01:   next = S2;
          SYM10:   next = S1;
          default: next = S3;
        endcase
      end
      default: begin
        unique case (sym)
          SYM00:   next = S0;
          SYM01:   next = S3;
          SYM10:   next = S2;
          default: next = S0;
        endcase
      end
    endcase
  end

  assign z = (state == S0) || (state == S3);

endmodule

// File: rtl/z_fsm_path_driver.sv
// Steers the z-machine to a requested state along a shortest symbol path,
// keeping a cycle-accurate shadow of it and flagging z mismatches.
module z_fsm_path_driver
  import z_fsm_pkg::*;
#(
  parameter bit          CHECK_Z = 1'b1,
  parameter int unsigned DWELL   = 0
) (
  input  logic                 clk,
  input  logic                 reset_b,
  z_fsm_path_driver_if.slave   bus
);

  localparam logic [3:0] DWELL_CNT = 4'(DWELL);

  drv_state_e fsm;
  logic [1:0] shadow;
  logic [1:0] shadow_next;
  logic [1:0] sym;
  logic [1:0] tgt;
  logic [1:0] hop_tgt;
  logic [3:0] dwell;
  logic       done_r;
  logic       err_r;
  logic       z_exp;
  logic       accept;
  logic       mismatch;

  // First symbol of a shortest path from c to t; ties resolved to the lowest code.
  function automatic logic [1:0] hop(input logic [1:0] c, input logic [1:0] t);
    logic [1:0] s;
    s = SYM00;
    if (c == t) begin
      unique case (zstate_e'(c))
        S0:      s = HOLD_S0;
        S1:      s = HOLD_S1;
        S2:      s = HOLD_S2;
        default: s = HOLD_S3;
      endcase
    end else begin
      unique case (zstate_e'(c))
        S0:      s = (t == S1) ? SYM11 : SYM01;
        S1:      s = (t == S0) ? SYM00 : SYM01;
        S2:      s = (t == S3) ? SYM11 : SYM00;
        default: s = (t == S2) ? SYM10 : SYM00;
      endcase
    end
    return s;
  endfunction

  z_fsm_model u_model (
    .state (shadow),
    .sym   (sym),
    .next  (shadow_next),
    .z     (z_exp)
  );

  assign accept   = (fsm == IDLE) && !err_r && bus.req_valid;
  assign mismatch = CHECK_Z && (bus.obs_z != z_exp);

  // The symbol issued at the accepting edge must already aim at the new target.
  always_comb begin
    hop_tgt = shadow_next;
    if (accept)
      hop_tgt = bus.req_target;
    else if (fsm == DRIVE)
      hop_tgt = tgt;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fsm    <= IDLE;
      shadow <= S0;
      sym    <= SYM00;
      tgt    <= S0;
      dwell  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      shadow <= shadow_next;
      sym    <= hop(shadow_next, hop_tgt);
      done_r <= 1'b0;

      if (mismatch)
        err_r <= 1'b1;
      else if (bus.err_clr)
        err_r <= 1'b0;

      unique case (fsm)
        IDLE: begin
          if (accept) begin
            tgt   <= bus.req_target;
            dwell <= '0;
            fsm   <= DRIVE;
          end
        end
        default: begin
          if (mismatch || err_r) begin
            fsm <= IDLE;
          end else if (shadow == tgt) begin
            if (dwell == DWELL_CNT) begin
              done_r <= 1'b1;
              fsm    <= IDLE;
            end else begin
              dwell <= dwell + 4'd1;
            end
          end else begin
            dwell <= '0;
          end
        end
      endcase
    end
  end

  assign bus.drv_x     = sym[1];
  assign bus.drv_y     = sym[0];
  assign bus.busy      = (fsm == DRIVE);
  assign bus.done      = done_r;
  assign bus.cur_state = shadow;
  assign bus.err       = err_r;
  assign bus.req_ready = (fsm == IDLE) && !err_r;

endmodule
